// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot occupancy tracker: gate FSM
// state encoding and default sizing.
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OPEN     = 2'd1,
    WAIT_CLR = 2'd2
  } gate_state_e;

  localparam int DEF_CAPACITY    = 8;
  localparam int DEF_CNT_W       = 4;
  localparam int DEF_GATE_CYCLES = 16;

endpackage

// File: rtl/parking_gate_fsm.sv
// One barrier controller: grants a held request, keeps the barrier open for
// GATE_CYCLES cycles, then waits for the car to clear the sensor.
module parking_gate_fsm
  import parking_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic allow,
  output logic grant_pulse,
  output logic gate,
  output logic in_wait
);

  localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

  gate_state_e     state, state_nxt;
  logic [TW-1:0]   timer, timer_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_nxt   = timer;
    grant_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (req && allow) begin
          grant_pulse = 1'b1;
          state_nxt   = OPEN;
          timer_nxt   = TW'(GATE_CYCLES - 1);
        end
      end
      OPEN: begin
        if (timer == '0) state_nxt = WAIT_CLR;
        else             timer_nxt = timer - TW'(1);
      end
      WAIT_CLR: begin
        // A request still present here is the same car; only its release re-arms.
        if (!req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign gate    = (state == OPEN);
  assign in_wait = (state == WAIT_CLR);

endmodule

// File: rtl/parking_space_counter.sv
// Occupancy tracker: arbitrates entry/exit gate grants, updates the occupied
// count through one add/subtract datapath and registers the status flags.
module parking_space_counter
  import parking_pkg::*;
#(
  parameter int CAPACITY    = DEF_CAPACITY,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int GATE_CYCLES = DEF_GATE_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_gate,
  output logic             exit_gate,
  output logic             entry_deny,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] free,
  output logic             full,
  output logic             empty
);

  logic             entry_grant, exit_grant;
  logic             entry_wait, exit_wait;
  logic             entry_idle;
  logic             sub_mode;
  logic [CNT_W-1:0] operand_b, count_nxt;
  logic [CNT_W-1:0] count_r, free_r;
  logic             full_r, empty_r, deny_r;

  parking_gate_fsm #(.GATE_CYCLES(GATE_CYCLES)) u_entry (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (entry_req),
    .allow       (!full_r),
    .grant_pulse (entry_grant),
    .gate        (entry_gate),
    .in_wait     (entry_wait)
  );

  parking_gate_fsm #(.GATE_CYCLES(GATE_CYCLES)) u_exit (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (exit_req),
    .allow       (!empty_r),
    .grant_pulse (exit_grant),
    .gate        (exit_gate),
    .in_wait     (exit_wait)
  );

  assign entry_idle = !entry_gate && !entry_wait;

  // B is 1 only when exactly one side is granted, so simultaneous grants add zero.
  always_comb begin
    sub_mode  = exit_grant && !entry_grant;
    operand_b = '0;
    operand_b[0] = entry_grant ^ exit_grant;
    count_nxt = count_r + (operand_b ^ {CNT_W{sub_mode}}) + CNT_W'(sub_mode);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_r <= '0;
      free_r  <= CNT_W'(CAPACITY);
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      deny_r  <= 1'b0;
    end else begin
      count_r <= count_nxt;
      free_r  <= CNT_W'(CAPACITY) - count_nxt;
      full_r  <= (count_nxt == CNT_W'(CAPACITY));
      empty_r <= (count_nxt == '0);
      deny_r  <= entry_idle && entry_req && full_r;
    end
  end

  assign count      = count_r;
  assign free       = free_r;
  assign full       = full_r;
  assign empty      = empty_r;
  assign entry_deny = deny_r;

  a_entry_no_regrant: assert property (@(posedge clk) disable iff (!rst_n) entry_wait |-> !entry_grant);
  a_exit_no_regrant:  assert property (@(posedge clk) disable iff (!rst_n) exit_wait  |-> !exit_grant);

endmodule

// File: tb/tb_parking_space_counter.sv
// Randomized scoreboard bench for parking_space_counter against a
// car-level occupancy model.
module tb_parking_space_counter;

  localparam int CAP = 8;
  localparam int CW  = 4;
  localparam int GC  = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          entry_req, exit_req;
  logic          entry_gate, exit_gate, entry_deny;
  logic [CW-1:0] count, free;
  logic          full, empty;

  always #5 clk = ~clk;

  parking_space_counter #(.CAPACITY(CAP), .CNT_W(CW), .GATE_CYCLES(GC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .entry_gate (entry_gate),
    .exit_gate  (exit_gate),
    .entry_deny (entry_deny),
    .count      (count),
    .free       (free),
    .full       (full),
    .empty      (empty)
  );

  typedef struct {
    int eg, xg, deny, cnt, fr, fl, em;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  bit   done  = 1'b0;

  // Car-level model: occupancy, remaining open cycles per barrier, and
  // whether a served car is still sitting on the sensor.
  int occ = 0, e_left = 0, x_left = 0, m_deny = 0;
  bit e_served = 0, x_served = 0;

  function automatic void model_step(input bit rn, input bit er, input bit xr);
    bit was_full, was_empty, e_idle, x_idle, eg, xg;
    if (!rn) begin
      occ = 0; e_left = 0; x_left = 0; m_deny = 0; e_served = 0; x_served = 0;
      return;
    end
    was_full  = (occ == CAP);
    was_empty = (occ == 0);
    e_idle = (e_left == 0) && !e_served;
    x_idle = (x_left == 0) && !x_served;
    eg = e_idle && er && !was_full;
    xg = x_idle && xr && !was_empty;
    m_deny = (e_idle && er && was_full) ? 1 : 0;
    if (e_left > 0) begin e_left--; if (e_left == 0) e_served = 1; end
    else if (e_served) begin if (!er) e_served = 0; end
    else if (eg) e_left = GC;
    if (x_left > 0) begin x_left--; if (x_left == 0) x_served = 1; end
    else if (x_served) begin if (!xr) x_served = 0; end
    else if (xg) x_left = GC;
    occ = occ + int'(eg) - int'(xg);
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.eg = (e_left > 0); e.xg = (x_left > 0); e.deny = m_deny;
    e.cnt = occ; e.fr = CAP - occ; e.fl = (occ == CAP); e.em = (occ == 0);
    return e;
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
    end
  endtask

  // Monitor: one expected record per clock edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (done) break;
      if (exp_q.size() == 0) begin
        check("scoreboard_underflow", 0, 1);
      end else begin
        e = exp_q.pop_front();
        check("entry_gate", int'(entry_gate), e.eg);
        check("exit_gate",  int'(exit_gate),  e.xg);
        check("entry_deny", int'(entry_deny), e.deny);
        check("count",      int'(count),      e.cnt);
        check("free",       int'(free),       e.fr);
        check("full",       int'(full),       e.fl);
        check("empty",      int'(empty),      e.em);
      end
    end
  end

  int e_hold = 0, e_gap = 0, x_hold = 0, x_gap = 0;

  task automatic drive(input bit rn, input bit er, input bit xr);
    rst_n = rn; entry_req = er; exit_req = xr;
    model_step(rn, er, xr);
    exp_q.push_back(model_out());
    @(negedge clk);
  endtask

  // Per-side car generator: hold the sensor for a while, then leave a gap.
  task automatic next_req(inout int hold, inout int gap, input int gmax, output bit r);
    if (hold > 0) begin r = 1; hold--; end
    else if (gap > 0) begin r = 0; gap--; end
    else begin
      hold = $urandom_range(1, 30);
      gap  = $urandom_range(0, gmax);
      r = 0;
    end
  endtask

  initial begin
    bit er, xr, rn;
    int emax, xmax;
    // Reset held with a car waiting, then released: grant follows one edge later.
    drive(0, 1, 0);
    drive(0, 1, 0);
    for (int i = 0; i < 20; i++) drive(1, 1, 0);
    for (int i = 0; i < 5; i++)  drive(1, 0, 0);
    // Exit attempts on an empty lot after draining are covered by the drain phase;
    // first a directed exit-at-empty right after reset.
    drive(0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 0, 1);
    drive(1, 0, 0);
    for (int phase = 0; phase < 9; phase++) begin
      case (phase % 3)
        0:       begin emax = 2;  xmax = 120; end
        1:       begin emax = 10; xmax = 10;  end
        default: begin emax = 120; xmax = 2;  end
      endcase
      for (int c = 0; c < 400; c++) begin
        next_req(e_hold, e_gap, emax, er);
        next_req(x_hold, x_gap, xmax, xr);
        rn = !(phase % 3 == 1 && $urandom_range(0, 299) == 0);
        drive(rn, er, xr);
      end
    end
    // Fill completely, then hold entry while one car exits.
    drive(0, 0, 0);
    for (int car = 0; car < CAP; car++) begin
      for (int i = 0; i < 18; i++) drive(1, 1, 0);
      drive(1, 0, 0);
    end
    for (int i = 0; i < 3; i++)  drive(1, 1, 0);
    for (int i = 0; i < 20; i++) drive(1, 1, 1);
    for (int i = 0; i < 3; i++)  drive(1, 0, 0);
    // Reset while an exit gate is open.
    for (int i = 0; i < 4; i++) drive(1, 0, 1);
    drive(0, 0, 1);
    for (int i = 0; i < 3; i++) drive(1, 0, 0);
    done = 1'b1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout at %0t: got running, expected finished", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/parking_space_counter.md
Name: parking_space_counter

Overview:
- Sequential occupancy tracker for the smart parking lot. It is the control end that drives the add/subtract arithmetic: it decides when a car is added to or removed from the occupancy count.
- It accepts level requests from the entry and exit gate sensors and grants or denies each one. It opens each barrier for a fixed time and keeps the occupied, free, full and empty status for the display and sign logic.

Parameters:
- CAPACITY, 8, number of parking spaces (1..255).
- CNT_W, 4, count width; must satisfy 2^CNT_W > CAPACITY.
- GATE_CYCLES, 16, clock cycles a barrier stays open after a grant (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous reset, active-low.
- entry_req  input  1  car present at entry sensor (level, held until the car has passed).
- exit_req  input  1  car present at exit sensor (level).
- entry_gate  output  1  entry barrier open.
- exit_gate  output  1  exit barrier open.
- entry_deny  output  1  "LOT FULL" indication at entry.
- count  output  CNT_W  occupied spaces.
- free  output  CNT_W  CAPACITY - count.
- full  output  1  count == CAPACITY.
- empty  output  1  count == 0.

Behaviour:
- Clock and reset: one clock, clk. rst_n is synchronous and active-low, sampled on the rising clk edge.
- Reset values: count=0, free=CAPACITY, full=0, empty=1, entry_gate=0, exit_gate=0, entry_deny=0. Both gate FSMs go to IDLE and both timers go to 0.
- Reset mid-operation: an open gate closes on the next edge and the count returns to 0.
- Each gate has its own FSM with states IDLE, OPEN and WAIT_CLR.
- IDLE -> OPEN:
  - Entry side: when entry_req=1 and full=0.
  - Exit side: when exit_req=1 and empty=0.
- IDLE -> OPEN actions on the same edge:
  - count updates: +1 for entry, -1 for exit.
  - The gate output goes to 1.
  - The timer loads GATE_CYCLES-1.
  - Latency: request to gate high and count updated is 1 cycle.
- OPEN: the timer decrements each cycle. When the timer reaches 0, the gate drops and the FSM moves to WAIT_CLR. The gate is therefore high for exactly GATE_CYCLES cycles.
- WAIT_CLR -> IDLE when the request is 0. A request still held counts as the same car and is never re-granted.
- Entry deny:
  - entry_deny = registered (entry FSM in IDLE && entry_req && full).
  - It clears one cycle after entry_req drops or after full clears.
  - A denied car is granted automatically once space frees while it is still waiting.
- Exit with empty=1: not granted and no deny output. This is a sensor fault; the exit FSM stays in IDLE.
- Simultaneous events:
  - Entry and exit grants on the same edge leave count unchanged and open both gates.
  - full and empty are evaluated on the registered count before the edge. Entry at full with a same-cycle exit grant is denied; entry is granted the next cycle.
- Arithmetic:
  - The next count is produced by one CNT_W-bit add/subtract datapath, with mode S=1 for subtract (two's-complement B^S, carry-in S).
  - The carry-out is ignored because overflow and underflow are impossible by the guards.
  - When both or neither side is granted, the count holds.
- Status outputs: free, full and empty are registered and consistent with count in the same cycle.

Decomposition:
- Shared package parking_pkg holds:
  - the gate state encoding (IDLE=2'd0, OPEN=2'd1, WAIT_CLR=2'd2);
  - default CAPACITY, CNT_W and GATE_CYCLES.
- Sub-module parking_gate_fsm (ports: clk, rst_n, req, allow, grant_pulse, gate, in_wait), instantiated twice, once for entry and once for exit.
- The top level holds the counter, the add/subtract datapath, the status flags and the deny register.

Test Plan:
- Reset: drive rst_n=0 for 2 cycles with entry_req=1 -> count=0, free=8, empty=1, gates=0. Release rst_n -> entry_gate=1 one cycle later and count=1.
- Single entry: pulse entry_req for 20 cycles -> entry_gate high exactly 16 cycles, count 0->1 once, no second grant while the request is held.
- Fill lot: 8 entries -> full=1, free=0. A 9th entry_req -> entry_deny=1, entry_gate=0, count stays 8.
- Denied then freed: at count=8 hold entry_req and issue exit_req -> exit granted, count=7. Next cycle entry granted, count=8, entry_deny clears.
- Simultaneous entry and exit at count=3 on the same edge -> both gates open, count stays 3.
- Exit at empty: exit_req=1 with count=0 -> exit_gate stays 0, count stays 0. Assert rst_n=0 mid-OPEN at count=5 -> gate drops and count=0 next edge.
